tc_fetch_queue: RTL and testbench

- Instruction-fetch stage that sits directly downstream of the byte-addressed 64-bit file ROM.
- Drives the ROM's en/address inputs from a program counter.
- Captures the 64-bit little-endian word the ROM returns one clock later and buffers it in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; supports a redirect input for taken branches.

---
 rtl/tc_fetch_queue_if.sv | 22 ++
 rtl/tc_fetch_queue.sv | 65 ++++++
 tb/tb_tc_fetch_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tc_fetch_queue_if.sv
// tc_fetch_queue_if: ROM request/response, control and decode-side handshake for the fetch stage
interface tc_fetch_queue_if;
    logic        rom_en;
    logic [15:0] rom_address;
    logic [63:0] rom_data;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] pc;
    modport master (
        output rom_en, rom_address, out_valid, out_instr, out_pc, pc,
        input  rom_data, halt, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  rom_en, rom_address, out_valid, out_instr, out_pc, pc,
        output rom_data, halt, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/tc_fetch_queue.sv
// tc_fetch_queue: drives a 1-cycle-latency ROM from a PC and buffers returned words in a credit-limited FIFO
module tc_fetch_queue #(
    parameter int          DEPTH       = 4,
    parameter int          INSTR_BYTES = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input logic              clk,
    input logic              rst,
    tc_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    logic [15:0]   r_pc, r_inflight_pc;
    logic          r_inflight;
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    logic [63:0]   r_instr [DEPTH];
    logic [15:0]   r_addr [DEPTH];
    logic [AW+1:0] w_used;
    logic          w_issue, w_push, w_pop, w_valid;
    // Queued plus in-flight words reserve slots, so a returning word always has room
    always_comb begin
        w_used  = {1'b0, r_count} + {{(AW+1){1'b0}}, r_inflight};
        w_issue = !rst && !bus.halt && !bus.redirect_valid && w_used < (AW+2)'(DEPTH);
        w_valid = r_count != '0;
        w_pop   = w_valid && bus.out_ready;
        w_push  = r_inflight && !bus.redirect_valid;
    end
    assign bus.rom_en      = w_issue;
    assign bus.rom_address = w_issue ? r_pc : 16'h0000;
    assign bus.out_valid   = w_valid;
    assign bus.out_instr   = w_valid ? r_instr[r_head] : 64'h0;
    assign bus.out_pc      = w_valid ? r_addr[r_head] : 16'h0000;
    assign bus.pc          = r_pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_pc;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_issue) r_pc <= r_pc + 16'(INSTR_BYTES);
                if (w_push) r_tail <= r_tail + AW'(1);
                if (w_pop) r_head <= r_head + AW'(1);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            assert (r_count < (AW+1)'(DEPTH));
            r_instr[r_tail] <= bus.rom_data;
            r_addr[r_tail]  <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_tc_fetch_queue.sv
// tb_tc_fetch_queue: two fetch queues (8-byte and 1-byte stride) against a queue-based reference model
module tb_tc_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          IB [2]   = '{8, 1};
    typedef logic [15:0] pcq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0, rv = 1'b0, ready = 1'b0;
    logic [15:0] rpc = 16'h0000;
    int          checks = 0, errors = 0;

    logic [15:0] mpc [2], mipc [2];
    bit          minf [2], miss [2], mrst [2];
    pcq_t        q0, q1;

    tc_fetch_queue_if bus0 ();
    tc_fetch_queue_if bus1 ();

    tc_fetch_queue #(.DEPTH(DEPTH), .INSTR_BYTES(8), .RESET_PC(RESET_PC)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    tc_fetch_queue #(.DEPTH(DEPTH), .INSTR_BYTES(1), .RESET_PC(RESET_PC)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    always #5 clk = ~clk;

    assign bus0.halt = halt;
    assign bus0.redirect_valid = rv;
    assign bus0.redirect_pc = rpc;
    assign bus0.out_ready = ready;
    assign bus1.halt = halt;
    assign bus1.redirect_valid = rv;
    assign bus1.redirect_pc = rpc;
    assign bus1.out_ready = ready;

    // ROM image: byte a holds a[7:0]^a[15:8]; a word reaching past 0xFFFF reads as zero
    function automatic logic [63:0] word(input logic [15:0] a);
        logic [63:0] w;
        logic [15:0] b;
        w = 64'h0;
        if (a > 16'hFFF8) return 64'h0;
        for (int k = 0; k < 8; k++) begin
            b = a + 16'(k);
            w[8*k +: 8] = b[7:0] ^ b[15:8];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        bus0.rom_data <= bus0.rom_en ? word(bus0.rom_address) : {$urandom, $urandom};
        bus1.rom_data <= bus1.rom_en ? word(bus1.rom_address) : {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic en, input logic [15:0] addr, input logic ov,
                            input logic [63:0] oi, input logic [15:0] op, input logic [15:0] pcv, input pcq_t q);
        miss[k] = !rst && !halt && !rv && (q.size() + int'(minf[k])) < DEPTH;
        chk($sformatf("i%0d rom_en", k), 80'(en), 80'(miss[k]));
        chk($sformatf("i%0d rom_address", k), 80'(addr), 80'(miss[k] ? mpc[k] : 16'h0000));
        chk($sformatf("i%0d out_valid", k), 80'(ov), 80'(q.size() > 0));
        chk($sformatf("i%0d pc", k), 80'(pcv), 80'(mpc[k]));
        if (q.size() > 0) begin
            chk($sformatf("i%0d out_pc", k), 80'(op), 80'(q[0]));
            chk($sformatf("i%0d out_instr", k), 80'(oi), 80'(word(q[0])));
        end else if (mrst[k]) begin
            chk($sformatf("i%0d reset out_pc", k), 80'(op), 80'(0));
            chk($sformatf("i%0d reset out_instr", k), 80'(oi), 80'(0));
        end
    endtask

    task automatic mupd(input int k, inout pcq_t q);
        mrst[k] = rst;
        if (rst) begin
            q.delete();
            minf[k] = 1'b0;
            mpc[k] = RESET_PC;
            return;
        end
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (rv) begin
            q.delete();
            mpc[k] = rpc;
        end else begin
            if (minf[k]) q.push_back(mipc[k]);
        end
        minf[k] = miss[k];
        if (miss[k]) begin
            mipc[k] = mpc[k];
            mpc[k] = mpc[k] + 16'(IB[k]);
        end
    endtask

    task automatic cyc(input logic r, input logic h, input logic v, input logic [15:0] p, input logic rd);
        @(negedge clk);
        rst = r; halt = h; rv = v; rpc = p; ready = rd;
        #1;
        chk_inst(0, bus0.rom_en, bus0.rom_address, bus0.out_valid, bus0.out_instr, bus0.out_pc, bus0.pc, q0);
        chk_inst(1, bus1.rom_en, bus1.rom_address, bus1.out_valid, bus1.out_instr, bus1.out_pc, bus1.pc, q1);
        @(posedge clk);
        mupd(0, q0);
        mupd(1, q1);
    endtask

    initial begin
        logic [15:0] pick;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            minf[k] = 1'b0; miss[k] = 1'b0; mrst[k] = 1'b1; mpc[k] = RESET_PC; mipc[k] = 16'h0000;
        end
        cyc(1, 0, 0, 16'h0, 1);
        repeat (6) cyc(0, 0, 0, 16'h0, 1);
        repeat (10) cyc(0, 0, 0, 16'h0, 0);
        repeat (8) cyc(0, 0, 0, 16'h0, 1);
        repeat (3) cyc(0, 0, 0, 16'h0, 0);
        cyc(0, 0, 1, 16'h0100, 0);
        repeat (6) cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'hFFF8, 1);
        repeat (5) cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'hFFFE, 1);
        repeat (6) cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'h0040, 1);
        cyc(0, 1, 1, 16'h0080, 1);
        cyc(0, 0, 0, 16'h0, 1);
        repeat (4) cyc(0, 1, 0, 16'h0, 1);
        repeat (3) cyc(0, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 16'h0, 0);
        repeat (3) cyc(0, 0, 0, 16'h0, 1);
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                pick, $urandom_range(0, 2) != 0);
        end
        repeat (8) cyc(0, 0, 0, 16'h0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
